// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between display fetch,
// a CPU port and a clear/fill engine. Every clk cycle is one memory slot.
// Grant in cycle N -> registered mem_* in N+1 -> RAM data and ack in N+2.
module vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_active,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          clr_req,
  input  logic [AW-1:0] clr_addr,
  input  logic [DW-1:0] clr_wdata,
  output logic          clr_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  // Grant identity carried down the two-stage tag pipeline.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VID  = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;
  localparam logic [1:0] TAG_CLR  = 2'd3;

  logic [1:0]    grant_s;
  logic          cpu_elig_s;
  logic          clr_elig_s;
  logic          starved_s;
  logic [1:0]    tag1_r;
  logic [1:0]    tag2_r;
  logic          cpu_busy_r;
  logic          clr_busy_r;
  logic          rr_clr_r;      // 1: CLR wins the next blanking tie
  logic [CW-1:0] starve_cnt_r;
  logic [AW-1:0] mem_addr_r;
  logic          mem_we_r;
  logic [DW-1:0] mem_wdata_r;

  // Per-slot arbitration: fetch first, then a starved clear, then the
  // active-display CPU preference or the blanking round-robin.
  always_comb begin
    cpu_elig_s = cpu_req & ~cpu_busy_r;
    clr_elig_s = clr_req & ~clr_busy_r;
    starved_s  = (starve_cnt_r == STARVE_LIM);
    grant_s    = TAG_NONE;
    if (vid_req) begin
      grant_s = TAG_VID;
    end else if (starved_s && clr_elig_s) begin
      grant_s = TAG_CLR;
    end else if (vid_active) begin
      if (cpu_elig_s) begin
        grant_s = TAG_CPU;
      end else if (clr_elig_s) begin
        grant_s = TAG_CLR;
      end else begin
        grant_s = TAG_NONE;
      end
    end else if (cpu_elig_s && clr_elig_s) begin
      grant_s = rr_clr_r ? TAG_CLR : TAG_CPU;
    end else if (cpu_elig_s) begin
      grant_s = TAG_CPU;
    end else if (clr_elig_s) begin
      grant_s = TAG_CLR;
    end else begin
      grant_s = TAG_NONE;
    end
  end

  // Register the granted access onto the memory port; idle slots keep the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
    end else begin
      case (grant_s)
        TAG_VID: begin
          mem_addr_r <= vid_addr;
          mem_we_r   <= 1'b0;
        end
        TAG_CPU: begin
          mem_addr_r  <= cpu_addr;
          mem_we_r    <= cpu_we;
          mem_wdata_r <= cpu_wdata;
        end
        TAG_CLR: begin
          mem_addr_r  <= clr_addr;
          mem_we_r    <= 1'b1;
          mem_wdata_r <= clr_wdata;
        end
        default: begin
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Carry grant identity to the cycle in which the RAM answers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag1_r <= TAG_NONE;
      tag2_r <= TAG_NONE;
    end else begin
      tag1_r <= grant_s;
      tag2_r <= tag1_r;
    end
  end

  // Busy flags keep a held level request from being granted twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_busy_r <= 1'b0;
      clr_busy_r <= 1'b0;
    end else begin
      if (grant_s == TAG_CPU) begin
        cpu_busy_r <= 1'b1;
      end else if (tag2_r == TAG_CPU) begin
        cpu_busy_r <= 1'b0;
      end
      if (grant_s == TAG_CLR) begin
        clr_busy_r <= 1'b1;
      end else if (tag2_r == TAG_CLR) begin
        clr_busy_r <= 1'b0;
      end
    end
  end

  // Count slots an eligible clear request has been passed over, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= '0;
    end else if (!clr_req || (grant_s == TAG_CLR)) begin
      starve_cnt_r <= '0;
    end else if (clr_elig_s && !starved_s) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end
  end

  // Round-robin pointer flips to the other requester after each CPU/CLR grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_clr_r <= 1'b0;
    end else if (grant_s == TAG_CPU) begin
      rr_clr_r <= 1'b1;
    end else if (grant_s == TAG_CLR) begin
      rr_clr_r <= 1'b0;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;

  assign vid_valid = (tag2_r == TAG_VID);
  assign cpu_ack   = (tag2_r == TAG_CPU);
  assign clr_ack   = (tag2_r == TAG_CLR);
  assign vid_data  = vid_valid ? mem_rdata : '0;
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a slot-level reference model.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int STARVE_MAX = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vid_active = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          clr_req = 1'b0;
  logic [AW-1:0] clr_addr = '0;
  logic [DW-1:0] clr_wdata = '0;
  logic          clr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .vid_active(vid_active),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clr_req(clr_req), .clr_addr(clr_addr), .clr_wdata(clr_wdata), .clr_ack(clr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h1234) return 8'hA5;
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous single-port RAM, read-before-write.
  logic [DW-1:0] ram [0:65535];
  bit            ram_valid [0:65535];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]       <= mem_wdata;
      ram_valid[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_valid[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle-time %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents in grant order, completion slots two
  // cycles after grant, requester availability as absolute cycle numbers.
  logic [DW-1:0] gmem [0:65535];
  int            cyc = 0;
  bit            iss_we [4];
  logic [AW-1:0] iss_addr [4];
  logic [DW-1:0] iss_wdata [4];
  int            ack_kind [4];   // 0 none, 1 vid, 2 cpu, 3 clr
  bit            ack_rd [4];
  logic [DW-1:0] ack_data [4];
  int            cpu_free_at = 0;
  int            clr_free_at = 0;
  int            clr_wait = 0;
  bit            prefer_clr = 1'b0;
  logic [AW-1:0] last_addr = '0;
  bit            cpu_acked = 1'b0;
  bit            clr_acked = 1'b0;
  int            obs_cpu = 0;
  int            obs_clr = 0;
  int            last_cpu_ack_cyc = -1;
  int            last_vid_cyc = -1;

  task automatic step();
    int s0, s1, s2, g;
    bit cpu_el, clr_el;
    s0 = cyc % 4;
    s1 = (cyc + 1) % 4;
    s2 = (cyc + 2) % 4;
    if (cpu_ack) begin obs_cpu++; last_cpu_ack_cyc = cyc; end
    if (clr_ack) obs_clr++;
    if (vid_valid) last_vid_cyc = cyc;
    if (!reset_n) begin
      check_val("rst_strobes", 32'({vid_valid, cpu_ack, clr_ack, mem_we}), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_val("rst_data", 32'({mem_wdata, vid_data, cpu_rdata}), 32'd0);
      for (int k = 0; k < 4; k++) begin
        iss_we[k] = 1'b0; iss_addr[k] = '0; iss_wdata[k] = '0;
        ack_kind[k] = 0; ack_rd[k] = 1'b0; ack_data[k] = '0;
      end
      cpu_free_at = 0; clr_free_at = 0; clr_wait = 0; prefer_clr = 1'b0;
      last_addr = '0; cpu_acked = 1'b0; clr_acked = 1'b0;
    end else begin
      check_val("mem_we", 32'(mem_we), 32'(iss_we[s0]));
      check_val("mem_addr", 32'(mem_addr), 32'(iss_addr[s0]));
      if (iss_we[s0]) check_val("mem_wdata", 32'(mem_wdata), 32'(iss_wdata[s0]));
      check_val("vid_valid", 32'(vid_valid), 32'(ack_kind[s0] == 1));
      if (ack_kind[s0] == 1) check_val("vid_data", 32'(vid_data), 32'(ack_data[s0]));
      check_val("cpu_ack", 32'(cpu_ack), 32'(ack_kind[s0] == 2));
      if (ack_kind[s0] == 2 && ack_rd[s0]) check_val("cpu_rdata", 32'(cpu_rdata), 32'(ack_data[s0]));
      check_val("clr_ack", 32'(clr_ack), 32'(ack_kind[s0] == 3));
      cpu_acked = (ack_kind[s0] == 2);
      clr_acked = (ack_kind[s0] == 3);
      if (iss_we[s0]) gmem[iss_addr[s0]] = iss_wdata[s0];

      cpu_el = cpu_req && (cyc >= cpu_free_at);
      clr_el = clr_req && (cyc >= clr_free_at);
      if (vid_req) g = 1;
      else if (clr_el && clr_wait >= STARVE_MAX) g = 3;
      else if (vid_active) g = cpu_el ? 2 : (clr_el ? 3 : 0);
      else if (cpu_el && clr_el) g = prefer_clr ? 3 : 2;
      else g = cpu_el ? 2 : (clr_el ? 3 : 0);

      iss_we[s1] = 1'b0; iss_addr[s1] = last_addr; iss_wdata[s1] = '0;
      ack_kind[s2] = g; ack_rd[s2] = 1'b0; ack_data[s2] = '0;
      case (g)
        1: begin
          iss_addr[s1] = vid_addr; ack_rd[s2] = 1'b1; ack_data[s2] = gmem[vid_addr];
        end
        2: begin
          iss_addr[s1] = cpu_addr; iss_we[s1] = cpu_we; iss_wdata[s1] = cpu_wdata;
          ack_rd[s2] = !cpu_we; ack_data[s2] = gmem[cpu_addr];
          cpu_free_at = cyc + 3; prefer_clr = 1'b1;
        end
        3: begin
          iss_addr[s1] = clr_addr; iss_we[s1] = 1'b1; iss_wdata[s1] = clr_wdata;
          clr_free_at = cyc + 3; prefer_clr = 1'b0;
        end
        default: ;
      endcase
      last_addr = iss_addr[s1];
      if (!clr_req || g == 3) clr_wait = 0;
      else if (clr_el) clr_wait = (clr_wait < STARVE_MAX) ? clr_wait + 1 : STARVE_MAX;
    end
    cyc++;
  endtask

  // One slot: check and model mid-cycle, then return just after the next edge.
  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input int vp, input int cp, input int lp, input int am);
    vid_req  = ($urandom_range(0, 99) < vp);
    vid_addr = 16'($urandom);
    if (am == 0) vid_active = 1'b0;
    else if (am == 1) vid_active = 1'b1;
    else if ($urandom_range(0, 99) < 8) vid_active = ~vid_active;
    if (!cpu_req || cpu_acked) begin
      cpu_req   = ($urandom_range(0, 99) < cp);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 47));
      cpu_wdata = 8'($urandom);
    end else if ($urandom_range(0, 99) < 25) begin
      cpu_addr  = 16'($urandom_range(0, 47));
      cpu_wdata = 8'($urandom);
    end
    if (!clr_req || clr_acked) begin
      clr_req   = ($urandom_range(0, 99) < lp);
      clr_addr  = 16'($urandom_range(0, 47));
      clr_wdata = 8'($urandom);
    end else if ($urandom_range(0, 99) < 25) begin
      clr_addr  = 16'($urandom_range(0, 47));
      clr_wdata = 8'($urandom);
    end
  endtask

  task automatic rand_phase(input int n, input int vp, input int cp, input int lp, input int am);
    for (int i = 0; i < n; i++) begin
      drive_rand(vp, cp, lp, am);
      tick();
    end
  endtask

  task automatic idle(input int n);
    vid_req = 1'b0; cpu_req = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int start, c0, k0, pulses;
    logic [DW-1:0] rd;
    for (int a = 0; a < 65536; a++) gmem[a] = init_val(16'(a));

    // Power-on reset, then release and confirm no stale strobes.
    tick(); tick();
    reset_n = 1'b1;
    idle(3);

    // CPU read of 0x1234 while idle: one ack carrying 0xA5.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    pulses = 0; rd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) begin pulses++; rd = cpu_rdata; end
      step();
      @(posedge clk); #1;
      if (cpu_acked) cpu_req = 1'b0;
    end
    check_val("rd1234_pulses", 32'(pulses), 32'd1);
    check_val("rd1234_data", 32'(rd), 32'hA5);

    // Fetch and CPU collide: fetch first, CPU one slot behind.
    idle(3);
    start = cyc;
    vid_active = 1'b1; vid_req = 1'b1; vid_addr = 16'h0200;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h3C;
    tick();
    vid_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_acked) cpu_req = 1'b0;
      tick();
    end
    check_val("coll_vid_lat", 32'(last_vid_cyc - start), 32'd2);
    check_val("coll_cpu_lat", 32'(last_cpu_ack_cyc - start), 32'd3);

    // Blanking with both CPU and CLR held: grants alternate.
    idle(3);
    c0 = obs_cpu; k0 = obs_clr;
    rand_phase(60, 0, 100, 100, 0);
    check_val("rr_balance",
              32'(((obs_cpu - c0) - (obs_clr - k0) <= 1) && ((obs_clr - k0) - (obs_cpu - c0) <= 1)), 32'd1);
    check_val("rr_progress", 32'((obs_cpu - c0) >= 15), 32'd1);

    // Active display, heavy fetch, CPU always asking: clears still get through.
    idle(3);
    k0 = obs_clr;
    clr_wdata = 8'h20;
    rand_phase(300, 75, 100, 100, 1);
    check_val("starve_clr_served", 32'((obs_clr - k0) > 0), 32'd1);

    // Ten back-to-back fetches with CPU waiting, then CPU in the first gap.
    idle(4);
    c0 = obs_cpu;
    vid_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0007;
    for (int i = 0; i < 10; i++) begin
      vid_req = 1'b1; vid_addr = 16'($urandom);
      tick();
    end
    check_val("burst_no_cpu_ack", 32'(obs_cpu - c0), 32'd0);
    start = cyc;
    vid_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_acked) cpu_req = 1'b0;
      tick();
    end
    check_val("burst_cpu_lat", 32'(last_cpu_ack_cyc - start), 32'd2);
    check_val("burst_cpu_once", 32'(obs_cpu - c0), 32'd1);

    // General mixed traffic.
    idle(2);
    rand_phase(2500, 40, 50, 50, 2);

    // Reset in the middle of traffic: outputs drop at once, nothing stale afterwards.
    rand_phase(20, 50, 100, 100, 2);
    reset_n = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; clr_req = 1'b0;
    #1;
    check_val("async_rst_strobes", 32'({vid_valid, cpu_ack, clr_ack, mem_we}), 32'd0);
    check_val("async_rst_addr", 32'(mem_addr), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    c0 = obs_cpu; k0 = obs_clr;
    idle(3);
    check_val("post_rst_no_ack", 32'((obs_cpu - c0) + (obs_clr - k0)), 32'd0);
    rand_phase(800, 40, 60, 60, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
